// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation and
// FSM state encodings plus the default datapath widths.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = 5;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

endpackage

// File: rtl/mdu_iter_core.sv
// One iteration of the shared multiply/divide datapath, purely combinational.
// The accumulator holds {partial, operand bits} for both modes.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic               i_div,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [2*WIDTH-1:0] o_acc
);

    // Multiply: upper half += multiplicand when the low multiplier bit is set,
    // then the whole {carry, upper, lower} shifts right by one.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   mcand);
        logic [WIDTH:0] sum;
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        return {sum, acc[WIDTH-1:1]};
    endfunction

    // Divide: shift the next dividend bit into the remainder and keep the
    // trial subtraction only when it does not go negative.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   dvsr);
        logic [WIDTH:0] trial;
        logic [WIDTH:0] diff;
        trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff  = trial - {1'b0, dvsr};
        if (trial >= {1'b0, dvsr})
            return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            return {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    endfunction

    assign o_acc = i_div ? div_step(i_acc, i_opnd) : mul_step(i_acc, i_opnd);

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Operates on magnitudes for 32 iterations, then applies sign correction.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_b_zero;
    logic               r_busy;
    logic               r_done;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = ~op[0];
    assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign w_a_neg  = w_signed & src_a[WIDTH-1];
    assign w_b_neg  = w_signed & src_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -src_a : src_a;
    assign w_b_mag  = w_b_neg ? -src_b : src_b;

    mdu_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_div  (r_div),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_next)
    );

    // A zero divisor must return all-ones in LO regardless of operand signs.
    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = (r_neg_q && !r_b_zero) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_div    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_div    <= w_is_div;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_b_zero <= (src_b == '0);
                        r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                        r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_CALC;
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                ST_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH-1))
                        r_state <= ST_FIN;
                end
                ST_FIN: begin
                    if (r_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mul_div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: the architectural result computed with 64-bit integer math.
    task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] eh, output logic [31:0] el);
        longint      sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin
                sp = sa * sb;
                up = sp;
                eh = up[63:32];
                el = up[31:0];
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                eh = up[63:32];
                el = up[31:0];
            end
            2'b10: begin
                if (b == 0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    up = sq;
                    el = up[31:0];
                    up = sr;
                    eh = up[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input bit with_hiwe);
        logic [31:0] eh, el;
        int          lat;
        bit          busy_ok;
        ref_model(o, a, b, eh, el);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        hi_we = with_hiwe; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        src_a = $urandom; src_b = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (disturb && lat == 5) begin
                start = 1'b1; op = 2'($urandom); lo_we = 1'b1; hi_we = 1'b1; wdata = $urandom;
            end else if (disturb && lat == 6) begin
                start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd33);
        check("busy_during_op", {63'b0, busy_ok}, 64'd1);
        check("busy_after_fin", {63'b0, busy}, 64'd0);
        check("hi_result", {32'b0, hi}, {32'b0, eh});
        check("lo_result", {32'b0, lo}, {32'b0, el});
        @(posedge clk); #1;
        check("done_one_cycle", {63'b0, done}, 64'd0);
    endtask

    initial begin
        logic [31:0] lo_keep;
        rst = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        @(negedge clk); rst = 1'b1;

        // Directed cases
        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op(2'b11, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        run_op(2'b10, 32'hF000_0001, 32'd0, 1'b0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);

        // MTHI alone, then both writes together
        lo_keep = lo;
        @(negedge clk); hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1; hi_we = 1'b0;
        check("mthi_hi", {32'b0, hi}, 64'hA5A5_A5A5);
        check("mthi_lo_keep", {32'b0, lo}, {32'b0, lo_keep});
        @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h3C3C_0F0F;
        @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
        check("mt_both_hi", {32'b0, hi}, 64'h3C3C_0F0F);
        check("mt_both_lo", {32'b0, lo}, 64'h3C3C_0F0F);

        // MTHI dropped when issued with start
        run_op(2'b01, 32'd3, 32'd5, 1'b0, 1'b1);

        // Reset mid-operation
        @(negedge clk); start = 1'b1; op = 2'b00; src_a = 32'd123; src_b = 32'd456;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_hi", {32'b0, hi}, 64'd0);
        check("abort_lo", {32'b0, lo}, 64'd0);
        @(negedge clk); rst = 1'b1;
        run_op(2'b00, 32'd123, 32'd456, 1'b0, 1'b0);

        // Random operations
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 6 == 5) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
            run_op(2'($urandom), ra, rb, (i % 4 == 1), (i % 5 == 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
